// File: rtl/or1200_thread_sched.sv
// Round-robin hardware-thread scheduler: picks the decode-stage thread and delays its ID to writeback.
// Optional build macro OR1200_THREAD_QUANTUM_EN keeps each thread for QUANTUM consecutive issues.
module or1200_thread_sched #(
    parameter int NTHREADS = 8,
    parameter int TW       = 3,
    parameter int WB_LAT   = 3,
    parameter int QUANTUM  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] thread_en,
    input  logic [NTHREADS-1:0] thread_stall,
    input  logic                id_freeze,
    input  logic                wb_freeze,
    input  logic                flushpipe,
    output logic [TW-1:0]       current_thread_read,
    output logic                issue_valid,
    output logic [TW-1:0]       current_thread_write,
    output logic                wb_valid,
    output logic                sched_idle
);

    logic [NTHREADS-1:0] elig_s;
    logic                any_elig_s;
    logic [TW-1:0]       rr_pick_s;
    logic [TW-1:0]       pick_s;
    logic [TW-1:0]       last_r;
    logic [TW-1:0]       tid_r;
    logic                iss_v_r;
    logic [WB_LAT-1:0]   stg_v_r;
    logic [TW-1:0]       stg_tid_r [WB_LAT];

    assign elig_s     = thread_en & ~thread_stall;
    assign any_elig_s = |elig_s;

    // Round-robin search from last_r+1; scanning downward lets the nearest eligible thread win
    always_comb begin
        logic [TW-1:0] idx_s;
        rr_pick_s = last_r;
        idx_s     = last_r;
        for (int i = NTHREADS; i >= 1; i--) begin
            idx_s     = last_r + TW'(i);
            rr_pick_s = elig_s[idx_s] ? idx_s : rr_pick_s;
        end
    end

`ifdef OR1200_THREAD_QUANTUM_EN
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    logic [QW-1:0] q_cnt_r;
    logic          hold_s;

    // Stay on the last issued thread until its quantum is spent or it drops out of eligibility
    assign hold_s = iss_v_r & elig_s[last_r] & (q_cnt_r != QW'(QUANTUM - 1));
    assign pick_s = hold_s ? last_r : rr_pick_s;

    // Quantum counter: counts consecutive issues of the held thread, restarts on rotation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_cnt_r <= {QW{1'b0}};
        end else if (wb_freeze) begin
            q_cnt_r <= q_cnt_r;
        end else if (flushpipe) begin
            q_cnt_r <= {QW{1'b0}};
        end else if (id_freeze) begin
            q_cnt_r <= q_cnt_r;
        end else if (any_elig_s) begin
            q_cnt_r <= hold_s ? (q_cnt_r + QW'(1)) : {QW{1'b0}};
        end else begin
            q_cnt_r <= q_cnt_r;
        end
    end
`else
    assign pick_s = rr_pick_s;

    // QUANTUM only shapes hardware when the quantum feature is built in
    if (QUANTUM < 1) begin : g_quantum_off
    end
`endif

    // Issue register and rotation pointer; wb_freeze beats flushpipe, which beats id_freeze
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tid_r   <= {TW{1'b0}};
            iss_v_r <= 1'b0;
            last_r  <= TW'(NTHREADS - 1);
        end else if (wb_freeze) begin
            iss_v_r <= iss_v_r;
        end else if (flushpipe) begin
            iss_v_r <= 1'b0;
        end else if (id_freeze) begin
            iss_v_r <= iss_v_r;
        end else if (any_elig_s) begin
            tid_r   <= pick_s;
            iss_v_r <= 1'b1;
            last_r  <= pick_s;
        end else begin
            iss_v_r <= 1'b0;
        end
    end

    // Issue-to-writeback delay line; id_freeze injects a bubble so a held issue is written back once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_v_r <= {WB_LAT{1'b0}};
            for (int i = 0; i < WB_LAT; i++) begin
                stg_tid_r[i] <= {TW{1'b0}};
            end
        end else if (wb_freeze) begin
            stg_v_r <= stg_v_r;
        end else if (flushpipe) begin
            stg_v_r <= {WB_LAT{1'b0}};
        end else begin
            stg_v_r[0]   <= iss_v_r & ~id_freeze;
            stg_tid_r[0] <= tid_r;
            for (int i = 1; i < WB_LAT; i++) begin
                stg_v_r[i]   <= stg_v_r[i-1];
                stg_tid_r[i] <= stg_tid_r[i-1];
            end
        end
    end

    assign current_thread_read  = tid_r;
    assign issue_valid          = iss_v_r;
    assign current_thread_write = stg_tid_r[WB_LAT-1];
    assign wb_valid             = stg_v_r[WB_LAT-1];
    assign sched_idle           = ~any_elig_s;

endmodule

// File: doc/or1200_thread_sched.md
# or1200_thread_sched

Round-robin hardware-thread scheduler for the multithreaded OR1200 core. It picks one eligible thread per cycle and drives the register file's `current_thread_read` at the decode stage. It also carries each issued thread ID down a delay pipeline, so the register file's `current_thread_write` and a write-valid qualifier line up with writeback. It sits directly upstream of `or1200_rf_top` and replaces testbench-driven thread selection.

## Interface
Parameters:
- `NTHREADS`, 8: number of hardware threads. Must equal 2**`TW`.
- `TW`, 3: thread-ID width.
- `WB_LAT`, 3: issue-to-writeback distance in cycles. Legal range 1..7.
- `QUANTUM`, 4: consecutive issues per thread. Used only with `OR1200_THREAD_QUANTUM_EN`.

Ports:
- `clk`  in  1  core clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `thread_en`  in  `NTHREADS`  per-thread enable (thread exists/running).
- `thread_stall`  in  `NTHREADS`  per-thread blocked (cache miss, SPR wait).
- `id_freeze`  in  1  hold the decode-stage selection.
- `wb_freeze`  in  1  hold the entire scheduler, including the delay pipeline.
- `flushpipe`  in  1  kill all in-flight issues.
- `current_thread_read`  out  `TW`  thread ID presented to the RF read ports.
- `issue_valid`  out  1  `current_thread_read` is a real issue, not a bubble.
- `current_thread_write`  out  `TW`  thread ID presented to the RF write ports.
- `wb_valid`  out  1  `current_thread_write` is a real writeback slot. The RF gates `we`/`we2` with this signal.
- `sched_idle`  out  1  no eligible thread this cycle.

## Operation
- Eligibility: `elig = thread_en & ~thread_stall`, evaluated combinationally each cycle.
- Pointer `last` (`TW` bits) holds the most recently issued thread.
- Next pick: the first set bit of `elig` scanning `last+1`, `last+2`, … modulo `NTHREADS`, with wrap-around. `last` itself is checked last, so a sole eligible thread reissues every cycle.
- Update rule, when not frozen (`~id_freeze & ~wb_freeze`):
  - If `|elig`: `current_thread_read` ← pick, `issue_valid` ← 1, `last` ← pick.
  - Else: `issue_valid` ← 0, and `current_thread_read` and `last` hold.
- `id_freeze` alone: the issue register holds, and a bubble (valid=0) enters pipeline stage 0.
- `wb_freeze`: every register holds, including the issue register and all pipeline stages. It takes precedence over `id_freeze`.
- Delay pipeline: `WB_LAT` stages of {valid, tid}. Stage 0 loads {`issue_valid`, `current_thread_read`}. The last stage drives `wb_valid`/`current_thread_write`.
- `flushpipe` (not frozen): clears `issue_valid` and every stage valid on that edge. The tids and `last` are kept. Issue resumes normally on the next cycle.
- `sched_idle` = `~|elig` (combinational).
- Reset values:
  - `current_thread_read` 0, `issue_valid` 0.
  - `current_thread_write` 0, `wb_valid` 0.
  - All stage valids 0.
  - `last` = `NTHREADS-1`, so the first issue is thread 0 if it is eligible.
  - Quantum counter 0.
- Reset mid-operation clears everything immediately, asynchronously. No partial state survives.

## Timing
- `elig` is sampled at edge n. The corresponding `current_thread_read`/`issue_valid` is visible after edge n (1-cycle select latency).
- A thread issued at edge n appears on `current_thread_write` with `wb_valid`=1 after edge n+`WB_LAT`, provided no `wb_freeze` intervenes. Each `wb_freeze` cycle adds one cycle.
- A `thread_stall` assertion at edge n prevents that thread from issuing at edge n. Threads already in flight are unaffected.
- Simultaneous `flushpipe` and `wb_freeze`: the freeze wins and the flush is ignored. The flush source must hold `flushpipe` until it is unfrozen.
- `thread_en` changes take effect on the same edge they are sampled.

## Configuration
- `OR1200_THREAD_QUANTUM_EN` defined:
  - A per-issue counter keeps the current thread selected for `QUANTUM` consecutive valid issues while it stays eligible.
  - The scheduler rotates when the counter reaches `QUANTUM-1`, or immediately if the thread becomes ineligible. The counter resets to 0 on every rotation.
  - The counter is frozen under `id_freeze`/`wb_freeze` and cleared by `flushpipe`.
- Macro undefined: rotation happens on every issue, as described above. No counter logic is present.

## Test plan
- Reset release with `thread_en`=8'hFF and no stall → `current_thread_read` = 0,1,2,…,7,0 on consecutive cycles with `issue_valid`=1. `current_thread_write` shows the same sequence 3 cycles later with `wb_valid`=1.
- `thread_en`=8'b0010_0101 → issue sequence 0,2,5,0,2. `thread_en`=8'b0000_1000 → thread 3 every cycle.
- All enabled, `thread_stall`=8'b0000_0010 held → sequence 0,2,3,…,7,0,2. Releasing the stall → 1 reappears after 0.
- `thread_en`=0 for 3 cycles → `sched_idle`=1 and `issue_valid`=0, `current_thread_read` holds its last value, and 3 `wb_valid`=0 slots appear 3 cycles later.
- Cases:
  - `id_freeze` for 2 cycles mid-sequence → `current_thread_read` holds and 2 bubbles reach writeback.
  - `wb_freeze` for 2 cycles → all outputs hold.
  - `flushpipe` pulse → `wb_valid`=0 for the next `WB_LAT` cycles, then issue resumes after the last issued thread.
- With `OR1200_THREAD_QUANTUM_EN`, `QUANTUM`=4, all enabled → 0,0,0,0,1,1,1,1. Stalling thread 1 during its second issue → rotates to 2 on the next cycle.
